regfile_wr_arb: RTL and testbench
=================================

REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: UART write-buffer entries; power of two, at least 2.
REQ-002 SHALL have parameter STARVE_LIMIT, default 7: consecutive starved cycles before pipe_stall asserts.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
 clk  in  1  clock, all state on rising edge
 rst_n  in  1  async active-low reset
 wb_we  in  1  writeback write request
 wb_addr  in  5  writeback destination register
 wb_data  in  32  writeback data
 epc_req  in  1  level request to write $k0; held until epc_ack
 epc_data  in  32  PC value to save in $k0; stable while epc_req=1
 epc_ack  out  1  one-cycle grant pulse for epc_req
 uart_signal  in  1  one-cycle pulse: new UART byte
 uart_flag  in  1  target select: 0 -> $a0 (r4), 1 -> $a1 (r5)
 uart_rx_data  in  8  UART byte
 rf_we  out  1  register-file write enable
 rf_addr  out  5  register-file write address
 rf_data  out  32  register-file write data
 pipe_stall  out  1  registered request to freeze writeback for one cycle
 fifo_count  out  log2(FIFO_DEPTH)+1  UART buffer occupancy
 uart_overflow  out  1  sticky: a UART byte was dropped

Function
REQ-005 SHALL arbitrate one register-file write port among three requesters, fixed priority: WB > EPC > UART.
REQ-006 SHALL treat a WB request as valid only when wb_we=1 and wb_addr != 0.
REQ-007 SHALL drive rf_we/rf_addr/rf_data combinationally from the winning requester in the same cycle; rf_we=0, rf_addr=0, rf_data=0 when no requester is valid.
REQ-008 SHALL grant EPC only when there is no valid WB request: rf_addr=26, rf_data=epc_data, epc_ack=1 for exactly that cycle.
REQ-009 SHALL keep epc_ack=0 in the cycle after a grant, even if epc_req is still high; a requester that keeps epc_req high is re-granted from the second cycle after the grant.
REQ-010 SHALL push {uart_flag, uart_rx_data} into the FIFO on any edge where uart_signal=1 and the count before that edge is below FIFO_DEPTH.
REQ-011 SHALL drop the byte and set uart_overflow on any edge where uart_signal=1 and the count is FIFO_DEPTH, even if a pop happens on the same edge.
REQ-012 SHALL grant the FIFO head when the FIFO is non-empty and there is no valid WB request and epc_req=0; it writes rf_addr = flag ? 5 : 4 and rf_data = zero-extended byte, and the head is popped on that edge.
REQ-013 SHALL apply push and pop together on the same edge when both occur and the count is below FIFO_DEPTH: the count is unchanged and order is preserved.
REQ-014 SHALL wrap the read/write pointers modulo FIFO_DEPTH.
REQ-015 SHALL give a minimum UART latency of: byte pulsed on edge N, written to the register file on edge N+1 when uncontended.
REQ-016 SHALL count, with a starve counter, the cycles where the FIFO is non-empty and ungranted; the counter clears on any UART grant or when the FIFO is empty.
REQ-017 SHALL set pipe_stall on the edge where the starve counter reaches STARVE_LIMIT, and clear it on the edge of the next UART grant.
REQ-018 SHALL not block a WB request while pipe_stall=1; the pipeline contract is wb_we=0 during stall; if WB still requests, WB wins and pipe_stall holds.
REQ-019 SHALL not let pipe_stall override EPC; EPC still beats UART during stall.

Reset
REQ-020 SHALL, while rst_n=0, immediately clear the FIFO pointers, fifo_count, the starve counter, pipe_stall and uart_overflow, and force epc_ack=0.
REQ-021 SHALL discard buffered UART bytes on a mid-operation reset; a pending epc_req is not remembered.

Structure
REQ-022 SHALL take REG_K0=26, REG_A0=4, REG_A1=5 and a grant enum {GNT_NONE, GNT_WB, GNT_EPC, GNT_UART} from shared package cpu_pkg.
REQ-023 SHALL place the FIFO in sub-module uart_wr_fifo (push, pop, full, empty, count, head); the arbiter, starve counter and overflow flag stay in regfile_wr_arb.

Verification
REQ-024 SHALL cover: FIFO empty, WB idle, UART pulse flag=1, data 8'hA5 -> next cycle rf_we=1, rf_addr=5, rf_data=32'h000000A5, fifo_count returns to 0.
REQ-025 SHALL cover: wb_we=1, wb_addr=26 and epc_req=1 in the same cycle -> WB written, epc_ack=0; next cycle with WB idle -> rf_addr=26, rf_data=epc_data, epc_ack=1.
REQ-026 SHALL cover: 5 UART pulses on consecutive edges while WB writes every cycle -> fifo_count=4, uart_overflow=1, the 5th byte is never written, and the first 4 bytes are written in order once WB is released.
REQ-027 SHALL cover: 1 byte buffered, WB writes r8 every cycle -> pipe_stall=1 after 7 starved cycles; drive wb_we=0 -> UART write occurs and pipe_stall=0 on the following edge.
REQ-028 SHALL cover: wb_we=1 with wb_addr=0 and 1 byte buffered -> UART granted that cycle.
REQ-029 SHALL cover: reset asserted with 3 bytes buffered and pipe_stall=1 -> fifo_count=0, pipe_stall=0 and rf_we=0 immediately, without a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register numbers and write-port grant encoding
package cpu_pkg;
   localparam logic [4:0] REG_K0 = 5'd26;
   localparam logic [4:0] REG_A0 = 5'd4;
   localparam logic [4:0] REG_A1 = 5'd5;

   typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_EPC, GNT_UART} grant_t;

   function automatic logic [4:0] uart_target(input logic flag);
      return flag ? REG_A1 : REG_A0;
   endfunction
endpackage

// File: rtl/uart_wr_fifo.sv
// rtl/uart_wr_fifo.sv - small power-of-two FIFO buffering UART register writes
module uart_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic [WIDTH-1:0]           head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointers are exactly AW bits wide, so wrap-around is the natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/regfile_wr_arb.sv
// rtl/regfile_wr_arb.sv - fixed-priority WB > EPC > UART register-file write arbiter
module regfile_wr_arb
   import cpu_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 7
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wb_we,
   input  logic [4:0]                    wb_addr,
   input  logic [31:0]                   wb_data,
   input  logic                          epc_req,
   input  logic [31:0]                   epc_data,
   output logic                          epc_ack,
   input  logic                          uart_signal,
   input  logic                          uart_flag,
   input  logic [7:0]                    uart_rx_data,
   output logic                          rf_we,
   output logic [4:0]                    rf_addr,
   output logic [31:0]                   rf_data,
   output logic                          pipe_stall,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          uart_overflow
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   grant_t        grant;
   logic          wb_valid;
   logic          epc_hold;
   logic          uart_grant;
   logic          fifo_full;
   logic          fifo_empty;
   logic [8:0]    fifo_head;
   logic [SW-1:0] starve_cnt;

   assign wb_valid   = wb_we && (wb_addr != 5'd0);
   assign uart_grant = (grant == GNT_UART);
   assign epc_ack    = (grant == GNT_EPC);

   uart_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (uart_signal),
      .push_data ({uart_flag, uart_rx_data}),
      .pop       (uart_grant),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   // Reset gates the grant so nothing reaches the register file while rst_n is low.
   always_comb begin
      grant = GNT_NONE;
      if (!rst_n)                    grant = GNT_NONE;
      else if (wb_valid)             grant = GNT_WB;
      else if (epc_req && !epc_hold) grant = GNT_EPC;
      else if (!epc_req && !fifo_empty) grant = GNT_UART;
   end

   always_comb begin
      rf_we   = 1'b0;
      rf_addr = 5'd0;
      rf_data = 32'd0;
      case (grant)
         GNT_WB: begin
            rf_we   = 1'b1;
            rf_addr = wb_addr;
            rf_data = wb_data;
         end
         GNT_EPC: begin
            rf_we   = 1'b1;
            rf_addr = REG_K0;
            rf_data = epc_data;
         end
         GNT_UART: begin
            rf_we   = 1'b1;
            rf_addr = uart_target(fifo_head[8]);
            rf_data = {24'd0, fifo_head[7:0]};
         end
         default: ;
      endcase
   end

   // epc_hold masks the cycle right after a grant so a held request is not seen twice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epc_hold      <= 1'b0;
         uart_overflow <= 1'b0;
         starve_cnt    <= '0;
         pipe_stall    <= 1'b0;
      end else begin
         epc_hold <= (grant == GNT_EPC);
         if (uart_signal && fifo_full) uart_overflow <= 1'b1;

         if (fifo_empty || uart_grant)             starve_cnt <= '0;
         else if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;

         if (uart_grant)
            pipe_stall <= 1'b0;
         else if (!fifo_empty && starve_cnt == SW'(STARVE_LIMIT - 1))
            pipe_stall <= 1'b1;
      end
   end
endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb/tb_regfile_wr_arb.sv - scoreboard bench for the register-file write arbiter
module tb_regfile_wr_arb;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_addr = 5'd0;
   logic [31:0] wb_data = 32'd0;
   logic        epc_req = 1'b0;
   logic [31:0] epc_data = 32'd0;
   logic        epc_ack;
   logic        uart_signal = 1'b0;
   logic        uart_flag = 1'b0;
   logic [7:0]  uart_rx_data = 8'd0;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        pipe_stall;
   logic [2:0]  fifo_count;
   logic        uart_overflow;

   int checks = 0;
   int failures = 0;
   bit mon_en = 1'b0;
   logic [36:0] uart_q[$];
   logic [36:0] mon_exp;

   always #5 clk = ~clk;

   regfile_wr_arb #(.FIFO_DEPTH(4), .STARVE_LIMIT(7)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wb_we         (wb_we),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .epc_req       (epc_req),
      .epc_data      (epc_data),
      .epc_ack       (epc_ack),
      .uart_signal   (uart_signal),
      .uart_flag     (uart_flag),
      .uart_rx_data  (uart_rx_data),
      .rf_we         (rf_we),
      .rf_addr       (rf_addr),
      .rf_data       (rf_data),
      .pipe_stall    (pipe_stall),
      .fifo_count    (fifo_count),
      .uart_overflow (uart_overflow)
   );

   function automatic logic [36:0] uexp(input logic flag, input logic [7:0] b);
      return {(flag ? 5'd5 : 5'd4), 24'd0, b};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Consumer side of the scoreboard: every register-file write is accounted for.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (wb_we && wb_addr != 5'd0) begin
            checks++;
            if (rf_we !== 1'b1 || rf_addr !== wb_addr || rf_data !== wb_data) begin
               failures++;
               $display("FAIL wb_pass rf_we=%0b addr=%0d data=%h expected addr=%0d data=%h",
                        rf_we, rf_addr, rf_data, wb_addr, wb_data);
            end
         end else if (epc_req && epc_ack) begin
            checks++;
            if (rf_we !== 1'b1 || rf_addr !== 5'd26 || rf_data !== epc_data) begin
               failures++;
               $display("FAIL epc_write rf_we=%0b addr=%0d data=%h expected addr=26 data=%h",
                        rf_we, rf_addr, rf_data, epc_data);
            end
         end else if (rf_we) begin
            checks++;
            if (uart_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write addr=%0d data=%h expected no write", rf_addr, rf_data);
            end else begin
               mon_exp = uart_q.pop_front();
               if ({rf_addr, rf_data} !== mon_exp) begin
                  failures++;
                  $display("FAIL uart_write addr=%0d data=%h expected addr=%0d data=%h",
                           rf_addr, rf_data, mon_exp[36:32], mon_exp[31:0]);
               end
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++;
      if (rf_we !== 1'b0 || epc_ack !== 1'b0 || fifo_count !== 3'd0 ||
          pipe_stall !== 1'b0 || uart_overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_state rf_we=%0b ack=%0b cnt=%0d stall=%0b ovf=%0b expected all 0",
                  rf_we, epc_ack, fifo_count, pipe_stall, uart_overflow);
      end
      cyc();
      cyc();
      rst_n = 1'b1;
      mon_en = 1'b1;
      cyc();
   endtask

   task automatic test_uart_basic();
      cyc();
      uart_signal = 1'b1; uart_flag = 1'b1; uart_rx_data = 8'hA5;
      uart_q.push_back(uexp(1'b1, 8'hA5));
      smp();
      checks++;
      if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin
         failures++;
         $display("FAIL uart_before_edge rf_we=%0b cnt=%0d expected 0 0", rf_we, fifo_count);
      end
      cyc();
      uart_signal = 1'b0;
      smp();
      checks++;
      if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'h0000_00A5 || fifo_count !== 3'd1) begin
         failures++;
         $display("FAIL uart_latency rf_we=%0b addr=%0d data=%h cnt=%0d expected 1 5 000000a5 1",
                  rf_we, rf_addr, rf_data, fifo_count);
      end
      cyc();
      smp();
      checks++;
      if (fifo_count !== 3'd0 || rf_we !== 1'b0 || uart_q.size() != 0) begin
         failures++;
         $display("FAIL uart_drain cnt=%0d rf_we=%0b pending=%0d expected 0 0 0",
                  fifo_count, rf_we, uart_q.size());
      end
   endtask

   task automatic test_wb_epc();
      cyc();
      wb_we = 1'b1; wb_addr = 5'd26; wb_data = 32'h1111_2222;
      epc_req = 1'b1; epc_data = 32'hBFC0_0180;
      smp();
      checks++;
      if (epc_ack !== 1'b0 || rf_addr !== 5'd26 || rf_data !== 32'h1111_2222) begin
         failures++;
         $display("FAIL wb_over_epc ack=%0b addr=%0d data=%h expected 0 26 11112222",
                  epc_ack, rf_addr, rf_data);
      end
      cyc();
      wb_we = 1'b0;
      smp();
      checks++;
      if (epc_ack !== 1'b1 || rf_we !== 1'b1 || rf_addr !== 5'd26 || rf_data !== 32'hBFC0_0180) begin
         failures++;
         $display("FAIL epc_grant ack=%0b rf_we=%0b addr=%0d data=%h expected 1 1 26 bfc00180",
                  epc_ack, rf_we, rf_addr, rf_data);
      end
      cyc();
      smp();
      checks++;
      if (epc_ack !== 1'b0 || rf_we !== 1'b0) begin
         failures++;
         $display("FAIL epc_gap ack=%0b rf_we=%0b expected 0 0", epc_ack, rf_we);
      end
      cyc();
      smp();
      checks++;
      if (epc_ack !== 1'b1) begin
         failures++;
         $display("FAIL epc_regrant ack=%0b expected 1", epc_ack);
      end
      cyc();
      epc_req = 1'b0;
      smp();
      checks++;
      if (epc_ack !== 1'b0) begin
         failures++;
         $display("FAIL epc_release ack=%0b expected 0", epc_ack);
      end
   endtask

   task automatic test_wb_zero();
      cyc();
      wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'hCAFE_0001;
      uart_signal = 1'b1; uart_flag = 1'b0; uart_rx_data = 8'h5A;
      uart_q.push_back(uexp(1'b0, 8'h5A));
      cyc();
      uart_signal = 1'b0; wb_addr = 5'd0; wb_data = 32'hDEAD_0000;
      smp();
      checks++;
      if (rf_we !== 1'b1 || rf_addr !== 5'd4 || rf_data !== 32'h0000_005A) begin
         failures++;
         $display("FAIL wb_r0_ignored rf_we=%0b addr=%0d data=%h expected 1 4 0000005a",
                  rf_we, rf_addr, rf_data);
      end
      cyc();
      wb_we = 1'b0;
      smp();
      checks++;
      if (fifo_count !== 3'd0 || uart_q.size() != 0) begin
         failures++;
         $display("FAIL wb_r0_drain cnt=%0d pending=%0d expected 0 0", fifo_count, uart_q.size());
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 5; i++) begin
         cyc();
         wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h100 + i;
         uart_signal = 1'b1; uart_flag = i[0]; uart_rx_data = 8'h30 + 8'(i);
         if (i < 4) uart_q.push_back(uexp(i[0], 8'h30 + 8'(i)));
         if (i == 4) begin
            smp();
            checks++;
            if (fifo_count !== 3'd4 || uart_overflow !== 1'b0) begin
               failures++;
               $display("FAIL fifo_full_no_ovf cnt=%0d ovf=%0b expected 4 0", fifo_count, uart_overflow);
            end
         end
      end
      cyc();
      uart_signal = 1'b0; wb_data = 32'h200;
      smp();
      checks++;
      if (fifo_count !== 3'd4 || uart_overflow !== 1'b1) begin
         failures++;
         $display("FAIL overflow cnt=%0d ovf=%0b expected 4 1", fifo_count, uart_overflow);
      end
      cyc();
      wb_we = 1'b0;
      repeat (5) cyc();
      smp();
      checks++;
      if (fifo_count !== 3'd0 || uart_q.size() != 0 || uart_overflow !== 1'b1) begin
         failures++;
         $display("FAIL overflow_drain cnt=%0d pending=%0d ovf=%0b expected 0 0 1",
                  fifo_count, uart_q.size(), uart_overflow);
      end
   endtask

   task automatic test_starve();
      cyc();
      wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h0000_0800;
      uart_signal = 1'b1; uart_flag = 1'b0; uart_rx_data = 8'h3C;
      uart_q.push_back(uexp(1'b0, 8'h3C));
      cyc();
      uart_signal = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         cyc();
         wb_data = 32'h0000_0800 + i;
         smp();
         checks++;
         if (pipe_stall !== (i == 7)) begin
            failures++;
            $display("FAIL starve_count cycle=%0d stall=%0b expected %0b", i, pipe_stall, (i == 7));
         end
      end
      cyc();
      smp();
      checks++;
      if (pipe_stall !== 1'b1 || rf_addr !== 5'd8) begin
         failures++;
         $display("FAIL stall_wb_wins stall=%0b addr=%0d expected 1 8", pipe_stall, rf_addr);
      end
      cyc();
      wb_we = 1'b0;
      smp();
      checks++;
      if (rf_we !== 1'b1 || rf_addr !== 5'd4 || rf_data !== 32'h0000_003C || pipe_stall !== 1'b1) begin
         failures++;
         $display("FAIL stall_uart_write rf_we=%0b addr=%0d data=%h stall=%0b expected 1 4 0000003c 1",
                  rf_we, rf_addr, rf_data, pipe_stall);
      end
      cyc();
      smp();
      checks++;
      if (pipe_stall !== 1'b0 || fifo_count !== 3'd0 || uart_q.size() != 0) begin
         failures++;
         $display("FAIL stall_clear stall=%0b cnt=%0d pending=%0d expected 0 0 0",
                  pipe_stall, fifo_count, uart_q.size());
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         cyc();
         wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h900 + i;
         uart_signal = 1'b1; uart_flag = 1'b1; uart_rx_data = 8'h70 + 8'(i);
      end
      cyc();
      uart_signal = 1'b0;
      repeat (8) cyc();
      smp();
      checks++;
      if (pipe_stall !== 1'b1 || fifo_count !== 3'd3) begin
         failures++;
         $display("FAIL pre_reset stall=%0b cnt=%0d expected 1 3", pipe_stall, fifo_count);
      end
      #1;
      mon_en = 1'b0;
      wb_we = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (fifo_count !== 3'd0 || pipe_stall !== 1'b0 || rf_we !== 1'b0 || uart_overflow !== 1'b0) begin
         failures++;
         $display("FAIL async_reset cnt=%0d stall=%0b rf_we=%0b ovf=%0b expected 0 0 0 0",
                  fifo_count, pipe_stall, rf_we, uart_overflow);
      end
      epc_req = 1'b1; epc_data = 32'h8000_0000;
      #1;
      checks++;
      if (epc_ack !== 1'b0 || rf_we !== 1'b0) begin
         failures++;
         $display("FAIL reset_epc ack=%0b rf_we=%0b expected 0 0", epc_ack, rf_we);
      end
      epc_req = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      mon_en = 1'b1;
      repeat (3) cyc();
      smp();
      checks++;
      if (fifo_count !== 3'd0 || rf_we !== 1'b0 || epc_ack !== 1'b0) begin
         failures++;
         $display("FAIL post_reset cnt=%0d rf_we=%0b ack=%0b expected 0 0 0", fifo_count, rf_we, epc_ack);
      end
   endtask

   initial begin
      test_reset();
      test_uart_basic();
      test_wb_epc();
      test_wb_zero();
      test_overflow();
      test_starve();
      test_reset_mid();
      cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1);
   end
endmodule
